distribute_tree_inject_seq: RTL and testbench
=============================================

DISTRIBUTE_TREE_INJECT_SEQ -- requirements
Module: distribute_tree_inject_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the payload width per beat.
REQ-002 The block SHALL have parameter NUM_LEAF, default 8, the number of tree leaves; it must be a power of 2 and at least 2.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, the number of ingress FIFO entries; it must be a power of 2.
REQ-004 The block SHALL have localparam CMD_WIDTH = log2(NUM_LEAF), the destination command width; its MSB is consumed by the tree root stage.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port s_valid, input, 1 bit: the producer offers a word.
REQ-008 The block SHALL have port s_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 The block SHALL have port s_data, input, DATA_WIDTH bits: the payload.
REQ-010 The block SHALL have port s_dest, input, CMD_WIDTH bits: the destination leaf index; bit=1 selects the high branch at each stage, MSB first.
REQ-011 The block SHALL have port s_sweep, input, 1 bit: replicate the payload to all leaves; s_dest is ignored when this bit is set.
REQ-012 The block SHALL have port i_tree_en, input, 1 bit: the tree root is enabled and consumes the output registers this cycle.
REQ-013 The block SHALL have port o_valid, output, 1 bit: the valid input to the tree root.
REQ-014 The block SHALL have port o_data_bus, output, DATA_WIDTH bits: the data input to the tree root.
REQ-015 The block SHALL have port o_cmd, output, CMD_WIDTH bits: the command input to the tree root.
REQ-016 The block SHALL have port o_busy, output, 1 bit: the FIFO is non-empty or the FSM is in SWEEP.
REQ-017 The block SHALL have port o_sent_cnt, output, 16 bits: the count of beats issued.

Function
REQ-018 A word SHALL be written to the FIFO when s_valid and s_ready are both high at the clock edge; {s_sweep, s_dest, s_data} is stored together.
REQ-019 s_ready SHALL equal !fifo_full; a push while full is impossible, with no same-cycle pass-through even if a pop occurs.
REQ-020 o_valid, o_data_bus, o_cmd SHALL be registers updated only on edges where i_tree_en=1; when i_tree_en=0 they hold, and no pop or sweep advance occurs.
REQ-021 The FSM SHALL have states IDLE and SWEEP, and each edge with i_tree_en=1 SHALL be evaluated as follows:
- IDLE, FIFO empty: o_valid<=0.
- IDLE, head unicast: o_valid<=1, o_data_bus<=head data, o_cmd<=head dest, pop the head.
- IDLE, head sweep: o_valid<=1, o_data_bus<=head data, o_cmd<=0, sweep_idx<=1, go to SWEEP; no pop yet.
- SWEEP: o_valid<=1, o_data_bus<=head data, o_cmd<=sweep_idx, sweep_idx<=sweep_idx+1; when sweep_idx==NUM_LEAF-1, pop the head and return to IDLE.
REQ-022 A sweep word SHALL produce exactly NUM_LEAF consecutive enabled beats with o_cmd = 0,1,...,NUM_LEAF-1, and the next FIFO entry SHALL follow with no bubble.
REQ-023 Latency SHALL be as follows: a word pushed at edge N with an empty FIFO, IDLE state and i_tree_en=1 appears on o_valid after edge N+1.
REQ-024 Unicast throughput SHALL be 1 beat per enabled cycle.
REQ-025 o_sent_cnt SHALL increment by 1 on every edge that loads o_valid<=1, and wrap from 0xFFFF to 0.
REQ-026 Pushes SHALL continue during SWEEP and during i_tree_en=0 until the FIFO is full.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set o_valid=0, o_data_bus=0, o_cmd=0, o_sent_cnt=0, FSM=IDLE, sweep_idx=0, FIFO empty, and o_busy=0; s_ready SHALL be 0 during reset.
REQ-029 Reset asserted mid-sweep or with the FIFO occupied SHALL abort the sweep and discard all stored words; the first edge after release behaves as IDLE with an empty FIFO.

Verification
REQ-030 The bench SHALL cover this scenario: reset, then push data 0xAAAAAAAA with dest 3'b101, i_tree_en=1 -> one cycle later o_valid=1, o_cmd=101, o_data_bus=0xAAAAAAAA, o_sent_cnt=1.
REQ-031 The bench SHALL cover this scenario: push sweep word 0xBBBBBBBB then unicast 0xCCCCCCCC with dest 2, i_tree_en=1 -> 8 beats with o_cmd 0..7 carrying 0xBBBBBBBB, then 0xCCCCCCCC with o_cmd=2 with no gap, o_sent_cnt=9.
REQ-032 The bench SHALL cover this scenario: hold i_tree_en=0, push 5 words -> s_ready falls after 4 accepts, outputs frozen; raise i_tree_en -> 4 beats in order, s_ready rises after the first pop.
REQ-033 The bench SHALL cover this scenario: drop i_tree_en at sweep beat 3 for 2 cycles -> o_cmd holds 3, then the sweep resumes at 4 with no beat lost or duplicated.
REQ-034 The bench SHALL cover this scenario: assert rst at sweep beat 5 with 2 words queued -> next cycle o_valid=0, o_sent_cnt=0, o_busy=0; after release with no pushes, o_valid stays 0.
REQ-035 The bench SHALL cover this scenario: preload o_sent_cnt to 0xFFFF by issuing 65535 unicast beats, then issue one more -> the count wraps to 0.

Source files
------------

// File: rtl/distribute_tree_inject_seq_if.sv
// Ingress handshake bundle for distribute_tree_inject_seq: producer offers
// {s_sweep, s_dest, s_data}, the block answers with s_ready.
interface distribute_tree_inject_seq_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_LEAF   = 8
);
    localparam int unsigned CMD_WIDTH = $clog2(NUM_LEAF);

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic [CMD_WIDTH-1:0]  s_dest;
    logic                  s_sweep;

    // Producer side
    modport master (output s_valid, output s_data, output s_dest, output s_sweep, input s_ready);
    // Block side
    modport slave  (input s_valid, input s_data, input s_dest, input s_sweep, output s_ready);
endinterface

// File: rtl/distribute_tree_inject_seq.sv
// Injects words into the root of a binary distribution tree. Words are queued
// in a small ingress FIFO; unicast words issue one beat addressed by s_dest,
// sweep words are replayed to every leaf (cmd 0..NUM_LEAF-1) before popping.
module distribute_tree_inject_seq #(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned NUM_LEAF   = 8,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CMD_WIDTH  = $clog2(NUM_LEAF)
) (
    input  logic                    clk,
    input  logic                    rst,
    distribute_tree_inject_seq_if.slave s,
    input  logic                    i_tree_en,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data_bus,
    output logic [CMD_WIDTH-1:0]    o_cmd,
    output logic                    o_busy,
    output logic [15:0]             o_sent_cnt
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CMD_WIDTH-1:0] LAST_IDX = CMD_WIDTH'(NUM_LEAF - 1);

    typedef struct packed {
        logic                  sweep;
        logic [CMD_WIDTH-1:0]  dest;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic {IDLE, SWEEP} state_t;

    entry_t               mem [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rd_ptr;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    entry_t               head;
    state_t               state;
    logic [CMD_WIDTH-1:0] sweep_idx;

    // Extra pointer MSB separates full from empty when the indices match
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // Ready only reflects stored occupancy, never a same-cycle pop
    assign s.s_ready = !fifo_full && !rst;
    assign push      = s.s_valid && s.s_ready;
    assign head      = mem[rd_ptr[PTR_W-1:0]];

    // A unicast head leaves at once; a sweep head leaves on its last leaf beat
    assign pop = i_tree_en && !fifo_empty &&
                 (((state == IDLE) && !head.sweep) ||
                  ((state == SWEEP) && (sweep_idx == LAST_IDX)));

    assign o_busy = !fifo_empty || (state == SWEEP);

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= {s.s_sweep, s.s_dest, s.s_data};
        end
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Issue FSM driving the registered tree-root inputs and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sweep_idx  <= '0;
            o_valid    <= 1'b0;
            o_data_bus <= '0;
            o_cmd      <= '0;
            o_sent_cnt <= '0;
        end else if (i_tree_en) begin
            case (state)
                IDLE: begin
                    if (fifo_empty) begin
                        o_valid <= 1'b0;
                    end else begin
                        o_valid    <= 1'b1;
                        o_data_bus <= head.data;
                        o_sent_cnt <= o_sent_cnt + 16'd1;
                        if (head.sweep) begin
                            o_cmd     <= '0;
                            sweep_idx <= CMD_WIDTH'(1);
                            state     <= SWEEP;
                        end else begin
                            o_cmd <= head.dest;
                        end
                    end
                end
                SWEEP: begin
                    o_valid    <= 1'b1;
                    o_data_bus <= head.data;
                    o_cmd      <= sweep_idx;
                    o_sent_cnt <= o_sent_cnt + 16'd1;
                    sweep_idx  <= sweep_idx + 1'b1;
                    if (sweep_idx == LAST_IDX) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_distribute_tree_inject_seq.sv
// Self-checking bench for distribute_tree_inject_seq: a scoreboard of expected
// beats fed on accepted pushes and drained by the beats the tree root consumes,
// a vector table, and hand sequences for pause, reset and counter wrap.
module tb_distribute_tree_inject_seq;
    localparam int unsigned DW = 32;
    localparam int unsigned NL = 8;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_tree_en = 1'b0;
    logic          o_valid;
    logic [DW-1:0] o_data_bus;
    logic [CW-1:0] o_cmd;
    logic          o_busy;
    logic [15:0]   o_sent_cnt;

    distribute_tree_inject_seq_if #(.DATA_WIDTH(DW), .NUM_LEAF(NL)) bus ();

    distribute_tree_inject_seq #(
        .DATA_WIDTH(DW),
        .NUM_LEAF  (NL),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus),
        .i_tree_en (i_tree_en),
        .o_valid   (o_valid),
        .o_data_bus(o_data_bus),
        .o_cmd     (o_cmd),
        .o_busy    (o_busy),
        .o_sent_cnt(o_sent_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] cmd;
    } beat_t;

    typedef struct {
        bit            sweep;
        logic [CW-1:0] dest;
        logic [DW-1:0] data;
        int            exp_beats;
    } vec_t;

    beat_t       sb[$];
    vec_t        vecs[6];
    logic [15:0] exp_cnt = 16'd0;
    logic [15:0] cnt_ref = 16'd0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Edge-time capture of what the DUT saw
    logic          en_q = 1'b0;
    logic          rst_q = 1'b1;
    logic          acc_q = 1'b0;
    logic          sw_q = 1'b0;
    logic [CW-1:0] dest_q = '0;
    logic [DW-1:0] data_q = '0;
    logic          pv_valid = 1'b0;
    logic [DW-1:0] pv_data = '0;
    logic [CW-1:0] pv_cmd = '0;

    always @(posedge clk) begin
        en_q   <= i_tree_en;
        rst_q  <= rst;
        acc_q  <= bus.s_valid && bus.s_ready;
        sw_q   <= bus.s_sweep;
        dest_q <= bus.s_dest;
        data_q <= bus.s_data;
    end

    // Scoreboard update and beat comparison, half a cycle after each edge
    always @(negedge clk) begin : mon
        int    pushed;
        beat_t e;
        pushed = 0;
        if (rst_q) begin
            sb.delete();
            exp_cnt = 16'd0;
        end else begin
            if (acc_q) begin
                if (sw_q) begin
                    for (int k = 0; k < int'(NL); k++) begin
                        e.data = data_q;
                        e.cmd  = CW'(k);
                        sb.push_back(e);
                    end
                    pushed = NL;
                end else begin
                    e.data = data_q;
                    e.cmd  = dest_q;
                    sb.push_back(e);
                    pushed = 1;
                end
            end
            if (!en_q) begin
                check("hold_valid", o_valid, pv_valid);
                check("hold_data", o_data_bus, pv_data);
                check("hold_cmd", o_cmd, pv_cmd);
            end else if (o_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    exp_cnt = exp_cnt + 16'd1;
                    check("beat_data", o_data_bus, e.data);
                    check("beat_cmd", o_cmd, e.cmd);
                    check("beat_cnt", o_sent_cnt, exp_cnt);
                end
            end else begin
                check("no_bubble", sb.size(), pushed);
            end
        end
        pv_valid = o_valid;
        pv_data  = o_data_bus;
        pv_cmd   = o_cmd;
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic push_word(input bit sw, input logic [CW-1:0] d, input logic [DW-1:0] dat);
        int g;
        bit ok;
        bus.s_valid = 1'b1;
        bus.s_sweep = sw;
        bus.s_dest  = d;
        bus.s_data  = dat;
        g = 0;
        do begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!ok && g < 200);
        if (!ok) check("push_timeout", 0, 1);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((o_busy || sb.size() != 0) && g < 100);
        if (o_busy || sb.size() != 0) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.s_ready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data_bus, 0);
        check("rst_cmd", o_cmd, 0);
        check("rst_cnt", o_sent_cnt, 0);
        check("rst_busy", o_busy, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int first;
        int last;
        int run;
        int g;
        int sum;

        bus.s_valid = 1'b0;
        bus.s_sweep = 1'b0;
        bus.s_dest  = '0;
        bus.s_data  = '0;
        i_tree_en   = 1'b1;

        do_reset();

        // Single unicast: one-cycle latency after the push edge
        push_word(1'b0, 3'b101, 32'hAAAA_AAAA);
        @(negedge clk);
        check("lat_not_early", o_valid, 0);
        @(negedge clk);
        check("uni_valid", o_valid, 1);
        check("uni_cmd", o_cmd, 3'b101);
        check("uni_data", o_data_bus, 32'hAAAA_AAAA);
        check("uni_cnt", o_sent_cnt, 16'd1);
        @(posedge clk);
        #1;
        wait_drain();

        // Sweep followed by unicast: 9 back-to-back beats
        do_reset();
        push_word(1'b1, 3'd0, 32'hBBBB_BBBB);
        push_word(1'b0, 3'd2, 32'hCCCC_CCCC);
        run = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (o_valid) begin
                run++;
                if (first < 0) first = i;
                last = i;
            end
        end
        check("sweep_beats", run, 9);
        check("sweep_contig", last - first + 1, 9);
        check("sweep_last_cmd", o_cmd, 3'd2);
        check("sweep_last_data", o_data_bus, 32'hCCCC_CCCC);
        check("sweep_cnt", o_sent_cnt, 16'd9);
        cnt_ref = 16'd9;
        @(posedge clk);
        #1;
        wait_drain();

        // Vector table streamed back to back
        vecs[0] = '{1'b0, 3'd1, 32'h0000_0011, 1};
        vecs[1] = '{1'b1, 3'd7, 32'h0000_0022, 8};
        vecs[2] = '{1'b0, 3'd7, 32'h0000_0033, 1};
        vecs[3] = '{1'b0, 3'd0, 32'h0000_0044, 1};
        vecs[4] = '{1'b1, 3'd3, 32'h0000_0055, 8};
        vecs[5] = '{1'b0, 3'd6, 32'h0000_0066, 1};
        sum = 0;
        foreach (vecs[i]) begin
            push_word(vecs[i].sweep, vecs[i].dest, vecs[i].data);
            sum += vecs[i].exp_beats;
        end
        wait_drain();
        cnt_ref = cnt_ref + 16'(sum);
        check("table_cnt", o_sent_cnt, cnt_ref);

        // Tree disabled: FIFO fills after four accepts, outputs frozen
        i_tree_en = 1'b0;
        for (int i = 0; i < 4; i++) push_word(1'b0, CW'(i + 1), 32'h5000_0000 + i);
        bus.s_valid = 1'b1;
        bus.s_sweep = 1'b0;
        bus.s_dest  = 3'd5;
        bus.s_data  = 32'h5000_0004;
        @(negedge clk);
        check("full_ready_low", bus.s_ready, 0);
        check("full_busy", o_busy, 1);
        repeat (2) @(negedge clk);
        check("full_ready_still_low", bus.s_ready, 0);
        check("frozen_cnt", o_sent_cnt, cnt_ref);
        @(posedge clk);
        #1;
        i_tree_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_pop", bus.s_ready, 1);
        check("first_pop_valid", o_valid, 1);
        check("first_pop_data", o_data_bus, 32'h5000_0000);
        check("first_pop_cmd", o_cmd, 3'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        wait_drain();
        cnt_ref = cnt_ref + 16'd5;
        check("fill_cnt", o_sent_cnt, cnt_ref);

        // Pause a sweep at leaf 3 for two edges
        push_word(1'b1, 3'd0, 32'hDDDD_DDDD);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(o_valid && o_cmd == 3'd3) && g < 20);
        check("pause_reach3", o_cmd, 3'd3);
        i_tree_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("pause_hold3", o_cmd, 3'd3);
            check("pause_hold_data", o_data_bus, 32'hDDDD_DDDD);
        end
        i_tree_en = 1'b1;
        @(negedge clk);
        check("pause_resume4", o_cmd, 3'd4);
        @(posedge clk);
        #1;
        wait_drain();
        cnt_ref = cnt_ref + 16'd8;
        check("pause_cnt", o_sent_cnt, cnt_ref);

        // Reset during sweep leaf 5 with two words queued behind it
        push_word(1'b1, 3'd0, 32'hEEEE_EEEE);
        push_word(1'b0, 3'd1, 32'h1111_1111);
        push_word(1'b0, 3'd6, 32'h2222_2222);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(o_valid && o_cmd == 3'd5) && g < 20);
        check("abort_reach5", o_cmd, 3'd5);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", o_valid, 0);
        check("abort_cnt", o_sent_cnt, 0);
        check("abort_busy", o_busy, 0);
        check("abort_ready", bus.s_ready, 0);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_abort_valid", o_valid, 0);
            check("post_abort_busy", o_busy, 0);
        end
        @(posedge clk);
        #1;

        // Beat counter wrap
        for (int i = 0; i < 65535; i++) push_word(1'b0, CW'(i), 32'(i));
        wait_drain();
        check("cnt_ffff", o_sent_cnt, 16'hFFFF);
        push_word(1'b0, 3'd4, 32'h1234_5678);
        wait_drain();
        check("cnt_wrap", o_sent_cnt, 16'h0000);
        check("wrap_data", o_data_bus, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
